// File: rtl/bcd_display_driver.sv
// ============================================================================
//  Module   : bcd_display_driver
//  Function : Double-dabble binary-to-BCD converter with a multiplexed,
//             active-low 7-segment display scanner.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bcd_display_driver #(
    parameter int NBITS    = 5,
    parameter int NDIGITS  = 2,
    parameter int SCAN_DIV = 1000,
    parameter int BLANK_LZ = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NBITS-1:0]       value_in,
    output logic                   busy,
    output logic                   done,
    output logic [4*NDIGITS-1:0]   bcd_out,
    output logic [NDIGITS-1:0]     an_n,
    output logic [6:0]             seg_n
);

    localparam int BCD_W = 4 * NDIGITS;
    localparam int CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NBITS-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   adj;

    logic [PRE_W-1:0]   pre_q;
    logic [IDX_W-1:0]   idx_q;
    logic [NDIGITS-1:0] an_n_q;
    logic [6:0]         seg_n_q;
    logic [3:0]         digit;
    logic               blank;
    logic [6:0]         seg_next;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        adj       = scratch_q;
        // Add-3 correction per nibble, applied before the shift.
        for (int i = 0; i < NDIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bin_d     = value_in;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                scratch_d = {adj[BCD_W-2:0], bin_q[NBITS-1]};
                bin_d     = bin_q << 1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(NBITS - 1))
                    state_d = S_DONE;
            end
            S_DONE: begin
                bcd_d   = scratch_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
        end
    end

    // Leading-zero run is accumulated from the most significant digit down.
    always_comb begin
        logic lz;
        lz    = 1'b1;
        digit = 4'd0;
        blank = 1'b0;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            lz = lz & (bcd_q[4*i +: 4] == 4'd0);
            if (idx_q == IDX_W'(i)) begin
                digit = bcd_q[4*i +: 4];
                blank = (BLANK_LZ != 0) && (i != 0) && lz;
            end
        end
    end

    assign seg_next = blank ? 7'b1111111 : seg7(digit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q   <= '0;
            idx_q   <= '0;
            an_n_q  <= ~NDIGITS'(1);
            seg_n_q <= 7'b1000000;
        end else begin
            if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
                pre_q <= '0;
                idx_q <= (idx_q == IDX_W'(NDIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
            end else begin
                pre_q <= pre_q + PRE_W'(1);
            end
            an_n_q  <= ~(NDIGITS'(1) << idx_q);
            seg_n_q <= seg_next;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign an_n    = an_n_q;
    assign seg_n   = seg_n_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_display_driver.sv
// ============================================================================
//  Module   : tb_bcd_display_driver
//  Function : Self-checking bench for bcd_display_driver (directed + random).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_display_driver;

    localparam int NBITS    = 5;
    localparam int NDIGITS  = 2;
    localparam int SCAN_DIV = 4;
    localparam int BLANK_LZ = 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [NBITS-1:0]     value_in;
    logic                 busy;
    logic                 done;
    logic [4*NDIGITS-1:0] bcd_out;
    logic [NDIGITS-1:0]   an_n;
    logic [6:0]           seg_n;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    bcd_display_driver #(
        .NBITS(NBITS), .NDIGITS(NDIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(BLANK_LZ)
    ) u_dut (
        .clk(clk), .reset(reset), .start(start), .value_in(value_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .an_n(an_n), .seg_n(seg_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    function automatic int to_bcd(input int v);
        int r = 0;
        int p = 1;
        for (int i = 0; i < NDIGITS; i++) begin
            r += ((v / p) % 10) << (4 * i);
            p *= 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input int bcd, input int idx);
        int upper = bcd >> (4 * idx);
        if (BLANK_LZ != 0 && idx > 0 && upper == 0) return 7'b1111111;
        return seg_tab[upper & 15];
    endfunction

    // Reference model: conversion as a countdown of busy cycles, display
    // derived from elapsed cycles since reset.
    int m_rem = 0, m_val = 0, m_bcd = 0, m_edges = 0;
    int m_disp_idx = 0, m_disp_bcd = 0;
    bit m_done = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_rem = 0; m_bcd = 0; m_edges = 0; m_done = 1'b0;
            m_disp_idx = 0; m_disp_bcd = 0;
        end else begin
            m_disp_idx = (m_edges / SCAN_DIV) % NDIGITS;
            m_disp_bcd = m_bcd;
            m_edges++;
            m_done = 1'b0;
            if (m_rem == 0) begin
                if (start) begin
                    m_rem = NBITS + 1;
                    m_val = int'(value_in);
                end
            end else begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1'b1;
                    m_bcd  = to_bcd(m_val);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_busy", 32'(busy), 32'(m_rem != 0));
            chk("m_done", 32'(done), 32'(m_done));
            chk("m_bcd", 32'(bcd_out), 32'(m_bcd));
            chk("m_an", 32'(an_n), 32'((~(1 << m_disp_idx)) & ((1 << NDIGITS) - 1)));
            chk("m_seg", 32'(seg_n), 32'(exp_seg(m_disp_bcd, m_disp_idx)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic conv(input int v, input logic [7:0] exp);
        int lat = -1;
        int nb  = 0;
        tick();
        start = 1'b1; value_in = NBITS'(v);
        tick();
        start = 1'b0;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) lat = i;
        end
        chk("conv_lat", 32'(lat), 32'(NBITS + 1));
        chk("conv_busy", 32'(nb), 32'(NBITS + 1));
        chk("conv_bcd", 32'(bcd_out), 32'(exp));
    endtask

    task automatic scan_check(input logic [6:0] s0, input logic [6:0] s1);
        int n0 = 0;
        tick(); tick();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (an_n == 2'b10) begin
                n0++;
                chk("scan_d0", 32'(seg_n), 32'(s0));
            end else begin
                chk("scan_an", 32'(an_n), 32'(2'b01));
                chk("scan_d1", 32'(seg_n), 32'(s1));
            end
        end
        chk("scan_dwell", 32'(n0), 32'd8);
    endtask

    initial begin
        int nd;
        int dc [$];
        reset = 1'b0; start = 1'b0; value_in = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd_out), 32'h00);
        chk("rst_an", 32'(an_n), 32'(2'b10));
        chk("rst_seg", 32'(seg_n), 32'(7'b1000000));

        conv(23, 8'h23);
        conv(31, 8'h31);
        conv(0, 8'h00);

        // Second request lands during SHIFT and must be dropped.
        tick();
        start = 1'b1; value_in = 5'd17;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; value_in = 5'd9;
        tick();
        start = 1'b0;
        nd = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("hs_ndone", 32'(nd), 32'd1);
        chk("hs_bcd", 32'(bcd_out), 32'h17);

        tick();
        start = 1'b1; value_in = NBITS'($urandom_range(0, 31));
        for (int i = 0; i < 40 && dc.size() < 3; i++) begin
            @(negedge clk);
            if (done) dc.push_back(cyc);
        end
        start = 1'b0;
        chk("held_n", 32'(dc.size()), 32'd3);
        if (dc.size() == 3) begin
            chk("held_gap1", 32'(dc[1] - dc[0]), 32'd7);
            chk("held_gap2", 32'(dc[2] - dc[1]), 32'd7);
        end
        repeat (10) tick();

        tick();
        start = 1'b1; value_in = 5'd23;
        tick();
        start = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_bcd", 32'(bcd_out), 32'h00);
        chk("mr_done", 32'(done), 32'd0);
        tick();
        reset = 1'b1;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("mr_nodone", 32'(nd), 32'd0);

        conv(7, 8'h07);
        scan_check(7'b1111000, 7'b1111111);
        conv(23, 8'h23);
        scan_check(7'b0110000, 7'b0100100);

        for (int i = 0; i < 400; i++) begin
            tick();
            start    = ($urandom_range(0, 3) == 0);
            value_in = NBITS'($urandom_range(0, 31));
            reset    = ($urandom_range(0, 149) != 0);
        end
        reset = 1'b1;
        start = 1'b0;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
